// File: rtl/ram_sized_hs.sv
// Byte-addressed RAM with byte/halfword/word access, a fixed access latency and
// an MFA/MFC four-phase handshake. Endianness and read sign extension are selectable.
module ram_sized_hs #(
  parameter int ADDR_W     = 8,
  parameter int LATENCY    = 2,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [1:0]        SIZE,
  input  logic              SGN,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MFC,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         dout_q, dout_d;
  logic                mfc_q, mfc_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [7:0]          mem_q [2**ADDR_W];

  logic [ADDR_W-3:0]   word_idx;
  logic [1:0]          off;
  logic                acc_err;
  logic                commit;
  logic [7:0]          rd_lane [4];
  logic [15:0]         rd_half;
  logic [31:0]         rd_word;
  logic [31:0]         rd_data;
  logic [3:0]          wr_en;
  logic [7:0]          wr_lane [4];

  assign word_idx = addr_q[ADDR_W-1:2];
  assign off      = addr_q[1:0];
  assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);

  // Aligned accesses never leave their word, so lanes are indexed inside word_idx only.
  assign acc_err = (size_q == 2'b11) ||
                   ((size_q == SZ_HALF) && off[0]) ||
                   ((size_q == SZ_WORD) && (off != 2'b00));

  always_comb begin
    for (int k = 0; k < 4; k++) rd_lane[k] = mem_q[{word_idx, 2'(k)}];
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rd_half = BIG_ENDIAN ? {rd_lane[{off[1], 1'b0}], rd_lane[{off[1], 1'b1}]}
                         : {rd_lane[{off[1], 1'b1}], rd_lane[{off[1], 1'b0}]};
    rd_word = BIG_ENDIAN ? {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]}
                         : {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    rd_data = rd_word;
    if (size_q == SZ_BYTE)
      rd_data = {{24{sgn_q & rd_lane[off][7]}}, rd_lane[off]};
    else if (size_q == SZ_HALF)
      rd_data = {{16{sgn_q & rd_half[15]}}, rd_half};
  end

  always_comb begin
    wr_en = 4'b0000;
    for (int k = 0; k < 4; k++) wr_lane[k] = 8'h00;
    case (size_q)
      SZ_BYTE: begin
        wr_en[off]   = 1'b1;
        wr_lane[off] = wdata_q[7:0];
      end
      SZ_HALF: begin
        wr_en[{off[1], 1'b0}]   = 1'b1;
        wr_en[{off[1], 1'b1}]   = 1'b1;
        wr_lane[{off[1], 1'b0}] = BIG_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
        wr_lane[{off[1], 1'b1}] = BIG_ENDIAN ? wdata_q[7:0]  : wdata_q[15:8];
      end
      SZ_WORD: begin
        for (int k = 0; k < 4; k++) begin
          wr_en[k]   = 1'b1;
          wr_lane[k] = BIG_ENDIAN ? wdata_q[8*(3-k) +: 8] : wdata_q[8*k +: 8];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (MFA) begin
          addr_d  = ADDR;
          rw_d    = RW;
          size_d  = SIZE;
          sgn_d   = SGN;
          wdata_d = DATA_IN;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          mfc_d   = 1'b1;
          err_d   = acc_err;
          if (rw_q && !acc_err) dout_d = rd_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!MFA) begin
          state_d = IDLE;
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'h0000_0000;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset; contents must survive CLR, and a reset would turn it into plain flops.
  always_ff @(posedge CLK) begin
    if (CLR && commit && !rw_q && !acc_err) begin
      for (int k = 0; k < 4; k++)
        if (wr_en[k]) mem_q[{word_idx, 2'(k)}] <= wr_lane[k];
    end
  end

  assign DATA_OUT = dout_q;
  assign MFC      = mfc_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule
